// File: rtl/cordic_arb_if.sv
// cordic_arb_if: requester-side and response-side bus of the CORDIC scheduler.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer that raises valid holds
// it, together with its payload, stable until that edge. Ready may depend
// combinationally on valid; valid never depends on ready.
//
// Signals:
//   req_valid  [NUM_REQ]     requester i has an operand pair
//   req_ready  [NUM_REQ]     one-hot grant from the scheduler
//   req_x_real [16*NUM_REQ]  packed real parts, requester i at [16i+15:16i]
//   req_x_imag [16*NUM_REQ]  packed imaginary parts, same packing
//   resp_valid               response available
//   resp_ready               downstream accepts the response
//   resp_angle [16]          angle sampled from the engine
//   resp_id    [ID_W]        index of the requester owning the response
//
// Modports: master = front ends / downstream, slave = the scheduler.
interface cordic_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_x_real;
  logic [16*NUM_REQ-1:0] req_x_imag;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [15:0]           resp_angle;
  logic [ID_W-1:0]       resp_id;

  modport master (
    output req_valid, req_x_real, req_x_imag, resp_ready,
    input  req_ready, resp_valid, resp_angle, resp_id
  );

  modport slave (
    input  req_valid, req_x_real, req_x_imag, resp_ready,
    output req_ready, resp_valid, resp_angle, resp_id
  );
endinterface

// File: rtl/cordic_arb.sv
// cordic_arb: round-robin scheduler sharing one CORDIC angle engine among
// NUM_REQ requesters. One operand pair is accepted at a time, driven to the
// engine and held for a settle window, then the engine angle is sampled and
// returned on a single tagged response channel.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     request/response bus (see cordic_arb_if)
//   o_busy          high whenever the FSM is not IDLE
//   o_eng_enable    engine enable, high only in RUN
//   o_eng_x_real    operand to engine (holds last value outside RUN)
//   o_eng_x_imag    operand to engine (holds last value outside RUN)
//   i_eng_angle     engine result
//   i_eng_ready     engine result valid
//   o_dbg_state     current FSM state (0 IDLE, 1 RUN, 2 RESP)
module cordic_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int SETTLE  = 2
) (
  input  logic        clk,
  input  logic        rst,
  cordic_arb_if.slave bus,
  output logic        o_busy,
  output logic        o_eng_enable,
  output logic [15:0] o_eng_x_real,
  output logic [15:0] o_eng_x_imag,
  input  logic [15:0] i_eng_angle,
  input  logic        i_eng_ready,
  output logic [1:0]  o_dbg_state
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ID_W-1:0]    r_last_grant;
  logic [ID_W-1:0]    r_cur_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_op_re;
  logic [15:0]        r_op_im;
  logic [15:0]        r_resp_angle;

  logic [NUM_REQ-1:0] w_grant_oh;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W-1:0]    w_scan_idx;
  logic               w_found;
  logic [15:0]        w_sel_re;
  logic [15:0]        w_sel_im;
  logic               w_take;
  logic               w_settled;
  logic               w_sample;

  // Circular search starting one past the last grant, so the last winner has
  // the lowest priority. The scan index wraps explicitly so NUM_REQ need not
  // be a power of two.
  always_comb begin
    w_grant_oh  = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_scan_idx  = r_last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = (w_scan_idx == LAST_IDX) ? '0 : w_scan_idx + ID_W'(1);
      if (!w_found && bus.req_valid[w_scan_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan_idx;
      end
    end
    w_grant_oh[w_grant_idx] = w_found;
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_re = '0;
    w_sel_im = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_oh[i]) begin
        w_sel_re = bus.req_x_real[16*i +: 16];
        w_sel_im = bus.req_x_imag[16*i +: 16];
      end
    end
  end

  // A grant is only ever offered to a valid requester, so an offered grant in
  // IDLE is a completed handshake at the next edge.
  assign w_take    = (r_state == S_IDLE) && w_found;
  assign w_settled = (r_cnt == CNT_LAST);
  assign w_sample  = (r_state == S_RUN) && w_settled && i_eng_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_take)         w_next_state = S_RUN;
      S_RUN:   if (w_sample)       w_next_state = S_RESP;
      S_RESP:  if (bus.resp_ready) w_next_state = S_IDLE;
      default:                     w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= LAST_IDX;
      r_cur_id     <= '0;
      r_cnt        <= '0;
      r_op_re      <= '0;
      r_op_im      <= '0;
      r_resp_angle <= '0;
    end else begin
      if (w_take) begin
        r_op_re      <= w_sel_re;
        r_op_im      <= w_sel_im;
        r_cur_id     <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_cnt        <= '0;
      end else if ((r_state == S_RUN) && !w_settled) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_sample) begin
        r_resp_angle <= i_eng_angle;
      end
    end
  end

  // Grant is suppressed outside IDLE, including the RESP cycle that accepts
  // the response.
  assign bus.req_ready  = (r_state == S_IDLE) ? w_grant_oh : '0;
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_angle = r_resp_angle;
  assign bus.resp_id    = r_cur_id;

  // Enable decodes the state register directly so it drops with reset,
  // without waiting for a clock.
  assign o_busy       = (r_state != S_IDLE);
  assign o_eng_enable = (r_state == S_RUN);
  assign o_eng_x_real = r_op_re;
  assign o_eng_x_imag = r_op_im;
  assign o_dbg_state  = r_state;

endmodule
